fxp_vec_alu: RTL and testbench

Parametrised, pipelined, multi-lane saturating fixed-point ALU. It accepts one vector of LANES signed Q(INT_BITS-1).FRAC_BITS operand pairs per cycle over a valid/ready handshake. It applies ADD, SUB, MUL or ABS with full-word saturation, and returns results with per-lane N/V/Z flags two cycles later. It sits in the Execution stage as the vector successor to the scalar fixed-point adder, feeding the writeback path, and keeps sticky per-lane overflow status for software.

---
 rtl/fxp_pkg.sv | 43 ++++
 rtl/fxp_lane.sv | 125 ++++++++++++
 rtl/fxp_vec_alu.sv | 93 +++++++++
 tb/tb_fxp_vec_alu.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// fxp_pkg: shared types and helpers for the fixed-point vector ALU.
//   fxp_op_e  : 2-bit operation code (ADD, SUB, MUL, ABS of A)
//   fxp_sat_t : saturated value plus overflow flag
//   fxp_sat() : clamp a sign-extended wide value into a w-bit signed range
package fxp_pkg;

    typedef enum logic [1:0] {
        FXP_ADD = 2'b00,
        FXP_SUB = 2'b01,
        FXP_MUL = 2'b10,
        FXP_ABS = 2'b11
    } fxp_op_e;

    // Widest intermediate the helper accepts; covers a full 2W product for W <= 32.
    localparam int FXP_MAX_W = 64;

    typedef struct packed {
        logic                 v;
        logic [FXP_MAX_W-1:0] val;
    } fxp_sat_t;

    // Clamp x (sign-extended to FXP_MAX_W) into [-2^(w-1), 2^(w-1)-1].
    // v is raised only when clamping actually happened.
    function automatic fxp_sat_t fxp_sat(input logic signed [FXP_MAX_W-1:0] x,
                                         input int unsigned              w);
        logic signed [FXP_MAX_W-1:0] hi;
        logic signed [FXP_MAX_W-1:0] lo;
        fxp_sat_t                    r;
        hi    = $signed((64'd1 << (w - 1)) - 64'd1);
        lo    = -hi - 64'sd1;
        r.v   = 1'b0;
        r.val = x;
        if (x > hi) begin
            r.v   = 1'b1;
            r.val = hi;
        end else if (x < lo) begin
            r.v   = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fxp_lane.sv
// fxp_lane: one lane of the fixed-point vector ALU.
//   Stage 1 registers the op and the raw result at extended width
//   (W+1 for ADD/SUB/ABS, 2W for MUL). Stage 2 rounds (MUL only),
//   saturates to W bits and derives N/V/Z from the saturated value.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   ld1, ld2       load enables for stage 1 / stage 2 (from top stall chain)
//   op             operation, shared by all lanes
//   a, b           W-bit two's complement operands
//   data, n, v, z  registered stage-2 result and flags
//   v_nxt          overflow flag about to be loaded into stage 2 (feeds sticky)
// Configuration: FXP_VEC_ALU_MUL_EN enables the multiplier; when undefined,
//   MUL yields 0 with Z=1, N=0, V=1.
module fxp_lane
    import fxp_pkg::*;
#(
    parameter  int INT_BITS  = 8,
    parameter  int FRAC_BITS = 8,
    localparam int W         = INT_BITS + FRAC_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld1,
    input  logic         ld2,
    input  fxp_op_e      op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] data,
    output logic         n,
    output logic         v,
    output logic         z,
    output logic         v_nxt
);

`ifdef FXP_VEC_ALU_MUL_EN
    localparam int RW = 2 * W;
    localparam logic signed [FXP_MAX_W-1:0] ROUND =
        (FRAC_BITS > 0) ? (64'sd1 <<< (FRAC_BITS - 1)) : 64'sd0;
`else
    localparam int RW = W + 1;
`endif

    logic signed [RW-1:0] raw_d, raw_q;
    fxp_op_e              op_q;

    logic [W-1:0] data_d;
    logic         n_d, z_d;

    // ---------------- stage 1: raw arithmetic ----------------
    always_comb begin
        logic signed [W:0] ea, eb;
`ifdef FXP_VEC_ALU_MUL_EN
        logic signed [2*W-1:0] wa, wb;
        wa = (2*W)'($signed(a));
        wb = (2*W)'($signed(b));
`endif
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        raw_d = '0;
        ea    = {a[W-1], a};
        eb    = {b[W-1], b};
        case (op)
            FXP_ADD: raw_d = RW'(ea + eb);
            FXP_SUB: raw_d = RW'(ea - eb);
            FXP_ABS: raw_d = RW'(a[W-1] ? -ea : ea);   // -(min) fits in W+1 bits
`ifdef FXP_VEC_ALU_MUL_EN
            FXP_MUL: raw_d = wa * wb;
`else
            FXP_MUL: raw_d = '0;
`endif
            default: raw_d = '0;
        endcase
    end

    // ---------------- stage 2: round / saturate / flags ----------------
    always_comb begin
        logic signed [FXP_MAX_W-1:0] wide;
        fxp_sat_t                    s;
        wide = FXP_MAX_W'(raw_q);
`ifdef FXP_VEC_ALU_MUL_EN
        // Round half up, then arithmetic shift back to the Q format.
        if (op_q == FXP_MUL) wide = (wide + ROUND) >>> FRAC_BITS;
`endif
        s      = fxp_sat(wide, W);
        data_d = s.val[W-1:0];
        v_nxt  = s.v;
`ifndef FXP_VEC_ALU_MUL_EN
        if (op_q == FXP_MUL) begin
            data_d = '0;
            v_nxt  = 1'b1;
        end
`endif
        n_d = data_d[W-1];
        z_d = (data_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= FXP_ADD;
            raw_q <= '0;
        end else if (ld1) begin
            op_q  <= op;
            raw_q <= raw_d;
        end
    end

    // NOTE: the result registers are reset because out_data and the flags
    // must read zero immediately when reset drops mid-stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            n    <= 1'b0;
            v    <= 1'b0;
            z    <= 1'b0;
        end else if (ld2) begin
            data <= data_d;
            n    <= n_d;
            v    <= v_nxt;
            z    <= z_d;
        end
    end

endmodule

// File: rtl/fxp_vec_alu.sv
// fxp_vec_alu: pipelined multi-lane saturating fixed-point ALU (Q(INT_BITS-1).FRAC_BITS).
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid, in_ready           operand-side handshake
//   in_op                        00 ADD, 01 SUB, 10 MUL, 11 ABS(A), shared by lanes
//   in_a, in_b                   LANES packed W-bit operands, lane i at [i*W +: W]
//   out_valid, out_ready         result-side handshake
//   out_data                     LANES packed saturated results
//   out_n, out_v, out_z          per-lane negative / saturated / zero flags
//   sticky_v, clr_sticky         per-lane sticky saturation and its clear
// Two-stage pipeline; a vector accepted at edge k is presented at edge k+2.
// Configuration: define FXP_VEC_ALU_MUL_EN to build the lane multipliers.
module fxp_vec_alu
    import fxp_pkg::*;
#(
    parameter  int INT_BITS  = 8,
    parameter  int FRAC_BITS = 8,
    parameter  int LANES     = 4,
    localparam int W         = INT_BITS + FRAC_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [LANES*W-1:0] in_a,
    input  logic [LANES*W-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic [LANES-1:0]   out_n,
    output logic [LANES-1:0]   out_v,
    output logic [LANES-1:0]   out_z,
    output logic [LANES-1:0]   sticky_v,
    input  logic               clr_sticky
);

    logic             v1, v2;
    logic             adv1, adv2;
    logic             ld1, ld2;
    logic [LANES-1:0] v_nxt;
    fxp_op_e          op;

    // Stall chain: a stage advances when it is empty or the one after it advances.
    // in_ready depends only on state and out_ready, never on in_valid.
    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign ld1       = adv1 && in_valid;
    assign ld2       = adv2 && v1;
    assign out_valid = v2;
    assign op        = fxp_op_e'(in_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (adv1) v1 <= in_valid;
            if (adv2) v2 <= v1;
        end
    end

    // A saturating load in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v <= '0;
        end else begin
            sticky_v <= (clr_sticky ? '0 : sticky_v) | (ld2 ? v_nxt : '0);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fxp_lane #(
            .INT_BITS  (INT_BITS),
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .ld1   (ld1),
            .ld2   (ld2),
            .op    (op),
            .a     (in_a[i*W +: W]),
            .b     (in_b[i*W +: W]),
            .data  (out_data[i*W +: W]),
            .n     (out_n[i]),
            .v     (out_v[i]),
            .z     (out_z[i]),
            .v_nxt (v_nxt[i])
        );
    end

endmodule

// File: tb/tb_fxp_vec_alu.sv
// tb_fxp_vec_alu: self-checking bench for fxp_vec_alu.
// A negedge monitor keeps a queue of expected vectors computed from plain
// integer arithmetic and compares every emitted vector in order; directed
// cases cover the documented corner values, stall, sticky and reset behaviour.
module tb_fxp_vec_alu;

    localparam int INT_BITS  = 8;
    localparam int FRAC_BITS = 8;
    localparam int W         = INT_BITS + FRAC_BITS;
    localparam int LANES     = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_op;
    logic [LANES*W-1:0] in_a, in_b;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*W-1:0] out_data;
    logic [LANES-1:0]   out_n, out_v, out_z;
    logic [LANES-1:0]   sticky_v;
    logic               clr_sticky;

    fxp_vec_alu #(
        .INT_BITS  (INT_BITS),
        .FRAC_BITS (FRAC_BITS),
        .LANES     (LANES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_n      (out_n),
        .out_v      (out_v),
        .out_z      (out_z),
        .sticky_v   (sticky_v),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*W-1:0] d;
        logic [LANES-1:0]   n, v, z;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_acc  = 0;
    int   n_out  = 0;
    int   v_cnt[LANES];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference lane: returns {n, v, z, data}.
    function automatic logic [W+2:0] ref_lane(input logic [1:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        longint    sa, sbv, x, maxv, minv;
        logic [W-1:0] d;
        logic      v;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        maxv = (longint'(1) << (W - 1)) - 1;
        minv = -maxv - 1;
        x    = 0;
        case (op)
            2'b00: x = sa + sbv;
            2'b01: x = sa - sbv;
            2'b11: x = (sa < 0) ? -sa : sa;
            default: begin
`ifdef FXP_VEC_ALU_MUL_EN
                x = (sa * sbv + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS;
`else
                return {1'b0, 1'b1, 1'b1, {W{1'b0}}};
`endif
            end
        endcase
        v = 1'b0;
        if (x > maxv) begin
            x = maxv; v = 1'b1;
        end else if (x < minv) begin
            x = minv; v = 1'b1;
        end
        d = W'(x);
        return {d[W-1], v, (d == '0), d};
    endfunction

    function automatic exp_t ref_vec(input logic [1:0] op,
                                     input logic [LANES*W-1:0] a,
                                     input logic [LANES*W-1:0] b);
        exp_t         e;
        logic [W+2:0] r;
        for (int i = 0; i < LANES; i++) begin
            r = ref_lane(op, a[i*W +: W], b[i*W +: W]);
            e.d[i*W +: W] = r[W-1:0];
            e.z[i] = r[W];
            e.v[i] = r[W+1];
            e.n[i] = r[W+2];
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        case ($urandom % 7)
            0: w = {1'b0, {(W-1){1'b1}}};
            1: w = {1'b1, {(W-1){1'b0}}};
            2: w = '0;
            3: w = '1;
            default: w = W'($urandom);
        endcase
        return w;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic                 hold_pending = 1'b0;
    logic [LANES*W-1:0]   hold_d;
    logic [3*LANES-1:0]   hold_f;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            exp_t e;
            check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
            if (hold_pending) begin
                check("hold_data", out_data, hold_d);
                check("hold_flags", {out_n, out_v, out_z}, hold_f);
            end
            hold_pending = out_valid && !out_ready;
            hold_d       = out_data;
            hold_f       = {out_n, out_v, out_z};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_n", out_n, e.n);
                    check("out_v", out_v, e.v);
                    check("out_z", out_z, e.z);
                    for (int i = 0; i < LANES; i++) if (e.v[i]) v_cnt[i]++;
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_vec(in_op, in_a, in_b));
                n_acc++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // One vector on an idle pipeline; the chosen lane gets (a0, b0), others random.
    task automatic run_one(input string tag, input int lane, input logic [1:0] op,
                           input logic [W-1:0] a0, input logic [W-1:0] b0,
                           output logic [W-1:0] d, output logic [2:0] nvz);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_op    = op;
        for (int i = 0; i < LANES; i++) begin
            in_a[i*W +: W] = (i == lane) ? a0 : rand_word();
            in_b[i*W +: W] = (i == lane) ? b0 : rand_word();
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            lat = i;
            if (out_valid) break;
        end
        check({"latency_", tag}, lat, 2);
        d   = out_data[lane*W +: W];
        nvz = {out_n[lane], out_v[lane], out_z[lane]};
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_sticky = 1'b1;
        @(posedge clk); #1 clr_sticky = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0]       d;
        logic [2:0]         nvz;
        logic [LANES*W-1:0] va[6], vb[6];
        logic [1:0]         vop[6];
        int                 idx, em, gaps, base_out, cyc;
        int                 v_base[LANES];
        logic               acc;

        for (int i = 0; i < LANES; i++) v_cnt[i] = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        out_ready = 1'b1; clr_sticky = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_flags", {out_n, out_v, out_z}, '0);
        check("rst_sticky", sticky_v, '0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk) rst_n = 1'b1;

        // Directed values.
        run_one("add", 0, 2'b00, 16'h0180, 16'h0240, d, nvz);
        check("add_data", d, 16'h03C0);
        check("add_nvz", nvz, 3'b000);

        pulse_clr();
        run_one("add_sat", 0, 2'b00, 16'h7F00, 16'h0200, d, nvz);
        check("add_sat_data", d, 16'h7FFF);
        check("add_sat_nvz", nvz, 3'b010);
        check("add_sat_sticky", sticky_v[0], 1'b1);

        pulse_clr();
        run_one("sub_sat", 1, 2'b01, 16'h8000, 16'h0100, d, nvz);
        check("sub_sat_data", d, 16'h8000);
        check("sub_sat_nvz", nvz, 3'b110);
        check("sub_sat_sticky", sticky_v[1], 1'b1);

`ifdef FXP_VEC_ALU_MUL_EN
        run_one("mul1", 0, 2'b10, 16'h0180, 16'h0200, d, nvz);
        check("mul1_data", d, 16'h0300);
        check("mul1_nvz", nvz, 3'b000);
        run_one("mul2", 2, 2'b10, 16'hFF80, 16'h0080, d, nvz);
        check("mul2_data", d, 16'hFFC0);
        check("mul2_nvz", nvz, 3'b100);
        run_one("mul3", 3, 2'b10, 16'h0001, 16'h0080, d, nvz);
        check("mul3_data", d, 16'h0001);
        run_one("mul4", 0, 2'b10, 16'hFFFF, 16'h0080, d, nvz);
        check("mul4_data", d, 16'h0000);
        check("mul4_nvz", nvz, 3'b001);
`else
        pulse_clr();
        run_one("mul_off", 0, 2'b10, 16'h0180, 16'h0200, d, nvz);
        check("mul_off_data", d, 16'h0000);
        check("mul_off_nvz", nvz, 3'b011);
        check("mul_off_sticky", sticky_v, {LANES{1'b1}});
`endif

        run_one("abs", 2, 2'b11, 16'h8000, 16'h0000, d, nvz);
        check("abs_data", d, 16'h7FFF);
        check("abs_nvz", nvz, 3'b010);

        // Sticky: set beats a simultaneous clear, a lone clear wins.
        pulse_clr();
        check("sticky_cleared", sticky_v, '0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 2'b00;
        in_a = '0; in_b = '0;
        in_a[W-1:0] = 16'h7F00; in_b[W-1:0] = 16'h0200;
        @(posedge clk); #1;                 // accepted
        in_valid = 1'b0; clr_sticky = 1'b1;
        @(posedge clk); #1;                 // stage-2 load with clear
        clr_sticky = 1'b0;
        check("sticky_set_wins", sticky_v[0], 1'b1);
        @(posedge clk); #1 clr_sticky = 1'b1;
        @(posedge clk); #1 clr_sticky = 1'b0;
        check("sticky_clear_alone", sticky_v, '0);

        // Stall: six vectors offered while the consumer holds off for five cycles.
        for (int i = 0; i < 6; i++) begin
            vop[i] = 2'($urandom % 4);
            for (int l = 0; l < LANES; l++) begin
                va[i][l*W +: W] = rand_word();
                vb[i][l*W +: W] = rand_word();
            end
        end
        @(posedge clk); #1;
        base_out = n_acc;
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1; in_op = vop[0]; in_a = va[0]; in_b = vb[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk) acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            in_valid = (idx < 6);
            if (idx < 6) begin in_op = vop[idx]; in_a = va[idx]; in_b = vb[idx]; end
        end
        check("stall_accepts", n_acc - base_out, 2);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        em = 0; gaps = 0;
        for (int c = 0; c < 30 && em < 6; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) em++; else gaps++;
            @(posedge clk); #1;
            if (acc) idx++;
            in_valid = (idx < 6);
            if (idx < 6) begin in_op = vop[idx]; in_a = va[idx]; in_b = vb[idx]; end
        end
        check("stream_emitted", em, 6);
        check("stream_gaps", gaps, 0);
        check("stream_sent", idx, 6);

        // Randomized traffic with random back-pressure.
        pulse_clr();
        for (int i = 0; i < LANES; i++) v_base[i] = v_cnt[i];
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            in_op     = 2'($urandom % 4);
            for (int l = 0; l < LANES; l++) begin
                in_a[l*W +: W] = rand_word();
                in_b[l*W +: W] = rand_word();
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_empty", exp_q.size(), 0);
        for (int i = 0; i < LANES; i++)
            check($sformatf("sticky_lane%0d", i), sticky_v[i], (v_cnt[i] - v_base[i]) > 0);

        // Reset with two vectors in flight.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        in_op = 2'b00; in_a = {LANES{16'h7FFF}}; in_b = {LANES{16'h0001}};
        @(posedge clk); #1;
        in_a = {LANES{16'h0101}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_reset_valid", out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, '0);
        check("reset_flags", {out_n, out_v, out_z}, '0);
        check("reset_sticky", sticky_v, '0);
        @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        out_ready = 1'b1;
        base_out = n_out;
        check("reset_in_ready", in_ready, 1'b1);
        em = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) em++;
        end
        check("post_reset_silent", em, 0);
        check("post_reset_no_out", n_out - base_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
